// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronise, debounce, edge-detect, queue and
// emit one-cycle coin codes to the vending machine.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sense_5,
    input  logic                          sense_10,
    input  logic                          hold,
    output logic [1:0]                    coin_out,
    output logic                          reject,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    s1_q, s1_d;
    logic [1:0]                    s2_q, s2_d;
    logic [1:0]                    db_q, db_d;
    logic [1:0]                    dbp_q, dbp_d;
    logic [1:0]                    arm_q, arm_d;
    logic [1:0]                    rdy_q, rdy_d;
    logic [1:0][CW-1:0]            cnt_q, cnt_d;
    logic [FIFO_DEPTH-1:0][1:0]    mem_q, mem_d;
    logic [AW-1:0]                 wp_q, wp_d;
    logic [AW-1:0]                 rp_q, rp_d;
    logic [NW-1:0]                 count_q, count_d;
    logic [GW-1:0]                 gap_q, gap_d;
    logic [1:0]                    coin_out_q, coin_out_d;
    logic                          reject_q, reject_d;

    logic [1:0] strobe;
    logic       push;
    logic       pop;
    logic [1:0] push_code;

    always_comb begin
        state_d    = state_q;
        s1_d       = {sense_10, sense_5};
        s2_d       = s1_q;
        db_d       = db_q;
        dbp_d      = db_q;
        cnt_d      = cnt_q;
        mem_d      = mem_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        gap_d      = gap_q;
        coin_out_d = coin_out_q;
        reject_d   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;

        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end

        // rdy marks that s2 holds real post-reset samples, so a sensor
        // stuck high through reset is never mistaken for a low level.
        rdy_d  = {rdy_q[0], 1'b1};
        arm_d  = arm_q | ({2{rdy_q[1]}} & ~s2_q & ~db_q);
        strobe = db_q & ~dbp_q & arm_q;

        unique case (state_q)
            IDLE: begin
                if (count_q != '0 && !hold) begin
                    pop        = 1'b1;
                    coin_out_d = mem_q[rp_q];
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                coin_out_d = 2'd0;
                gap_d      = '0;
                state_d    = GAP;
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                coin_out_d = 2'd0;
                state_d    = IDLE;
            end
        endcase

        push_code = strobe[1] ? 2'd2 : 2'd1;
        if (strobe == 2'b11) begin
            reject_d = 1'b1;
        end else if (strobe != 2'b00) begin
            if (count_q != DEPTH_N || pop) begin
                push = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end

        if (push) begin
            mem_d[wp_q] = push_code;
            wp_d        = wp_q + 1'b1;
        end
        if (pop) begin
            rp_d = rp_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            db_q       <= '0;
            dbp_q      <= '0;
            arm_q      <= '0;
            rdy_q      <= '0;
            cnt_q      <= '0;
            mem_q      <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            coin_out_q <= '0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            db_q       <= db_d;
            dbp_q      <= dbp_d;
            arm_q      <= arm_d;
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            coin_out_q <= coin_out_d;
            reject_q   <= reject_d;
        end
    end

    assign coin_out   = coin_out_q;
    assign reject     = reject_q;
    assign fifo_count = count_q;
    assign fifo_full  = (count_q == DEPTH_N);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed scoreboard bench for coin_acceptor: expected coin codes are
// queued as stimulus is driven and matched against logged emissions.
module tb_coin_acceptor;

    localparam int GAP = 2;
    localparam int LAT = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       sense_5;
    logic       sense_10;
    logic       hold;
    logic [1:0] coin_out;
    logic       reject;
    logic       fifo_full;
    logic [2:0] fifo_count;

    coin_acceptor dut (
        .clk        (clk),
        .rst        (rst),
        .sense_5    (sense_5),
        .sense_10   (sense_10),
        .hold       (hold),
        .coin_out   (coin_out),
        .reject     (reject),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_obs = 0;
    int         n_rej = 0;
    logic [1:0] obs_code [64];
    int         obs_cyc [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (coin_out !== 2'd0 && n_obs < 64) begin
            obs_code[n_obs] = coin_out;
            obs_cyc[n_obs]  = cyc;
            n_obs           = n_obs + 1;
        end
        if (reject === 1'b1) n_rej = n_rej + 1;
    end

    int         checks = 0;
    int         errors = 0;
    int         rd = 0;
    logic [1:0] exp_q [$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        logic [1:0] e;
        while (rd < n_obs) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL %s_extra observed=%0d expected=none",
                       tag, obs_code[rd]);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({tag, "_code"}, 32'(obs_code[rd]), 32'(e));
            end
            if (rd > 0) begin
                checks++;
                assert (obs_cyc[rd] - obs_cyc[rd-1] > GAP) else begin
                    errors++;
                    $error("FAIL %s_gap observed=%0d expected>%0d",
                           tag, obs_cyc[rd] - obs_cyc[rd-1], GAP);
                end
            end
            rd++;
        end
        chk({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic coin(input bit ten, input int hi, input int lo);
        if (ten) sense_10 = 1'b1;
        else     sense_5  = 1'b1;
        tick(hi);
        sense_10 = 1'b0;
        sense_5  = 1'b0;
        tick(lo);
    endtask

    initial begin
        int c0;
        int i1;
        int r0;
        rst      = 1'b0;
        sense_5  = 1'b0;
        sense_10 = 1'b0;
        hold     = 1'b0;
        tick(3);
        chk("rst_coin", 32'(coin_out), 32'd0);
        chk("rst_reject", 32'(reject), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b1;
        tick(6);

        // clean 10-cycle pulse, latency measured from first sampling edge
        exp_q.push_back(2'd1);
        i1 = n_obs;
        sense_5 = 1'b1;
        tick(1);
        c0 = cyc;
        tick(9);
        sense_5 = 1'b0;
        tick(20);
        chk("t1_latency", 32'(obs_cyc[i1] - c0), 32'(LAT));
        chk("t1_count", 32'(fifo_count), 32'd0);
        drain("t1");

        // bouncing 10-unit sensor
        r0 = n_rej;
        exp_q.push_back(2'd2);
        for (int k = 0; k < 4; k++) begin
            sense_10 = (k % 2 == 0);
            tick(1);
        end
        coin(1'b1, 6, 20);
        chk("t2_reject", 32'(n_rej - r0), 32'd0);
        drain("t2");

        // hold with 5 coins: queue fills, fifth is rejected
        hold = 1'b1;
        r0   = n_rej;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k % 2 == 1) ? 2'd2 : 2'd1);
            coin(k % 2 == 1, 6, 8);
        end
        chk("t3_full", 32'(fifo_full), 32'd1);
        chk("t3_count4", 32'(fifo_count), 32'd4);
        chk("t3_noreject", 32'(n_rej - r0), 32'd0);
        chk("t3_hold_idle", 32'(n_obs - rd), 32'd0);
        coin(1'b0, 6, 8);
        chk("t3_reject", 32'(n_rej - r0), 32'd1);
        chk("t3_count5", 32'(fifo_count), 32'd4);
        hold = 1'b0;
        tick(30);
        chk("t3_empty", 32'(fifo_count), 32'd0);
        drain("t3");

        // simultaneous rising edges on both sensors
        r0 = n_rej;
        sense_5  = 1'b1;
        sense_10 = 1'b1;
        tick(6);
        sense_5  = 1'b0;
        sense_10 = 1'b0;
        tick(14);
        chk("t4_reject", 32'(n_rej - r0), 32'd1);
        chk("t4_count", 32'(fifo_count), 32'd0);
        drain("t4");

        // sensor stuck high across reset must first go low
        sense_5 = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(20);
        chk("t5_stuck_count", 32'(fifo_count), 32'd0);
        drain("t5_stuck");
        exp_q.push_back(2'd1);
        sense_5 = 1'b0;
        tick(6);
        coin(1'b0, 6, 20);
        drain("t5");

        // reset while one coin emits and three are queued
        hold = 1'b1;
        for (int k = 0; k < 4; k++) coin(k % 2 == 1, 6, 8);
        chk("t6_count4", 32'(fifo_count), 32'd4);
        exp_q.push_back(2'd1);
        hold = 1'b0;
        tick(1);
        chk("t6_emit", 32'(coin_out), 32'd1);
        rst = 1'b0;
        tick(1);
        chk("t6_coin", 32'(coin_out), 32'd0);
        chk("t6_count", 32'(fifo_count), 32'd0);
        chk("t6_reject", 32'(reject), 32'd0);
        r0  = n_rej;
        rst = 1'b1;
        tick(30);
        chk("t6_no_reject", 32'(n_rej - r0), 32'd0);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
